// File: rtl/video_frame_monitor_pkg.sv
// Shared types, constants and the CRC step function for the video frame monitor.
package vfm_pkg;

    typedef enum logic [1:0] {
        VFM_IDLE,
        VFM_SYNC,
        VFM_CAPTURE,
        VFM_DONE
    } vfm_state_t;

    localparam logic [15:0] CRC16_POLY = 16'h1021;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;

    // Advance a CRC-16-CCITT register over the low nbits of data, MSB first.
    // Callers pass a constant nbits (at most 32), so the loop unrolls to pure XOR logic.
    function automatic logic [15:0] crc16_step(input logic [15:0] crc,
                                               input logic [31:0] data,
                                               input int nbits);
        logic [15:0] c;
        logic        fb;
        c  = crc;
        fb = 1'b0;
        for (int i = 31; i >= 0; i--) begin
            if (i < nbits) begin
                fb = c[15] ^ data[i];
                c  = {c[14:0], 1'b0};
                if (fb) begin
                    c = c ^ CRC16_POLY;
                end
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/video_frame_monitor_crc16.sv
// Registered CRC-16-CCITT accumulator: one DATA_W-bit word per update, MSB first.
// DATA_W must not exceed 32.
module vfm_crc16
    import vfm_pkg::*;
#(
    parameter int DATA_W = 9
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear_i,
    input  logic              update_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [15:0]       crc_o
);

    logic [15:0] crc_q;
    logic [15:0] crc_d;

    // Next CRC value: clear wins over update, otherwise hold.
    always_comb begin
        crc_d = crc_q;
        if (clear_i) begin
            crc_d = CRC16_INIT;
        end else if (update_i) begin
            crc_d = crc16_step(crc_q, 32'(data_i), DATA_W);
        end
    end

    // CRC register; starts at the CCITT seed after reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            crc_q <= CRC16_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/video_frame_monitor.sv
// Video frame monitor: segments a sync-delimited RGB stream into lines and frames,
// reporting per-frame CRC-16, line count, first-line length and a length-mismatch flag.
// Optional macro VFM_XY_OUT_EN adds pix_x/pix_y/pix_valid pixel-position outputs.
module video_frame_monitor
    import vfm_pkg::*;
#(
    parameter int COLOR_W    = 3,
    parameter int NUM_FRAMES = 3,
    parameter int MAX_X      = 1023,
    parameter int MAX_Y      = 511,
    localparam int X_W       = $clog2(MAX_X + 1),
    localparam int Y_W       = $clog2(MAX_Y + 1)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               clock_en,
    input  logic               enable,
    input  logic [COLOR_W-1:0] video_r,
    input  logic [COLOR_W-1:0] video_g,
    input  logic [COLOR_W-1:0] video_b,
    input  logic               hsync_n,
    input  logic               vsync_n,
    output logic               frame_done,
    output logic [15:0]        frame_crc,
    output logic [Y_W-1:0]     frame_lines,
    output logic [X_W-1:0]     line_len,
    output logic               line_err,
    output logic [7:0]         frame_count,
    output logic               done
`ifdef VFM_XY_OUT_EN
    ,
    output logic [X_W-1:0]     pix_x,
    output logic [Y_W-1:0]     pix_y,
    output logic               pix_valid
`endif
);

    vfm_state_t     state_q, state_d;
    logic           hsPrev_q, vsPrev_q;
    logic [X_W-1:0] pixCnt_q, pixCnt_d;
    logic [Y_W-1:0] lines_q, lines_d;
    logic [X_W-1:0] refLen_q, refLen_d;
    logic           err_q, err_d;
    logic [7:0]     frameCount_q, frameCount_d;
    logic           frameDone_q, frameDone_d;
    logic [15:0]    frameCrc_q;
    logic [Y_W-1:0] frameLines_q;
    logic [X_W-1:0] lineLen_q;
    logic           lineErr_q;

    logic           hsFall, vsFall, active, inCapture;
    logic           lineClose, frameClose, lastFrame, latch;
    logic           crcClear, crcUpdate;
    logic [15:0]    crcValue;
    logic [X_W-1:0] pixInc;
    logic [Y_W-1:0] linesInc, linesAfter;
    logic [X_W-1:0] refAfter;
    logic           errAfter;

    vfm_crc16 #(.DATA_W(3 * COLOR_W)) u_crc (
        .clock    (clock),
        .reset    (reset),
        .clear_i  (crcClear),
        .update_i (crcUpdate),
        .data_i   ({video_r, video_g, video_b}),
        .crc_o    (crcValue)
    );

    // Sync edge detection, saturating counters and the "line closed this sample" view
    // of the accumulators, so a frame close in the same sample sees the closed line.
    always_comb begin
        hsFall     = clock_en & hsPrev_q & ~hsync_n;
        vsFall     = clock_en & vsPrev_q & ~vsync_n;
        active     = clock_en & hsync_n & vsync_n;
        inCapture  = (state_q == VFM_CAPTURE);
        lineClose  = inCapture & hsFall & (pixCnt_q != '0);
        frameClose = inCapture & vsFall;
        lastFrame  = ((frameCount_q + 8'd1) == 8'(NUM_FRAMES));
        pixInc     = (pixCnt_q == X_W'(MAX_X)) ? pixCnt_q : pixCnt_q + 1'b1;
        linesInc   = (lines_q == Y_W'(MAX_Y)) ? lines_q : lines_q + 1'b1;
        linesAfter = lineClose ? linesInc : lines_q;
        refAfter   = (lineClose && lines_q == '0) ? pixCnt_q : refLen_q;
        errAfter   = err_q | (lineClose && lines_q != '0 && pixCnt_q != refLen_q);
    end

    // Next-state and accumulator control; enable low always returns to IDLE.
    always_comb begin
        state_d      = state_q;
        pixCnt_d     = pixCnt_q;
        lines_d      = lines_q;
        refLen_d     = refLen_q;
        err_d        = err_q;
        frameCount_d = frameCount_q;
        frameDone_d  = 1'b0;
        latch        = 1'b0;
        crcClear     = 1'b0;
        crcUpdate    = 1'b0;
        if (!enable) begin
            state_d      = VFM_IDLE;
            frameCount_d = '0;
        end else begin
            case (state_q)
                VFM_IDLE: state_d = VFM_SYNC;
                VFM_SYNC: begin
                    if (vsFall) begin
                        state_d  = VFM_CAPTURE;
                        pixCnt_d = '0;
                        lines_d  = '0;
                        refLen_d = '0;
                        err_d    = 1'b0;
                        crcClear = 1'b1;
                    end
                end
                VFM_CAPTURE: begin
                    if (frameClose) begin
                        latch        = 1'b1;
                        frameDone_d  = 1'b1;
                        frameCount_d = frameCount_q + 8'd1;
                        state_d      = lastFrame ? VFM_DONE : VFM_CAPTURE;
                        pixCnt_d     = '0;
                        lines_d      = '0;
                        refLen_d     = '0;
                        err_d        = 1'b0;
                        crcClear     = 1'b1;
                    end else if (active) begin
                        pixCnt_d  = pixInc;
                        crcUpdate = 1'b1;
                    end else if (lineClose) begin
                        lines_d  = linesInc;
                        refLen_d = refAfter;
                        err_d    = errAfter;
                        pixCnt_d = '0;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    // State, sync history, accumulators and the latched per-frame results.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= VFM_IDLE;
            hsPrev_q     <= 1'b1;
            vsPrev_q     <= 1'b1;
            pixCnt_q     <= '0;
            lines_q      <= '0;
            refLen_q     <= '0;
            err_q        <= 1'b0;
            frameCount_q <= '0;
            frameDone_q  <= 1'b0;
            frameCrc_q   <= '0;
            frameLines_q <= '0;
            lineLen_q    <= '0;
            lineErr_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            pixCnt_q     <= pixCnt_d;
            lines_q      <= lines_d;
            refLen_q     <= refLen_d;
            err_q        <= err_d;
            frameCount_q <= frameCount_d;
            frameDone_q  <= frameDone_d;
            if (clock_en) begin
                hsPrev_q <= hsync_n;
                vsPrev_q <= vsync_n;
            end
            if (latch) begin
                frameCrc_q   <= crcValue;
                frameLines_q <= linesAfter;
                lineLen_q    <= refAfter;
                lineErr_q    <= errAfter;
            end
        end
    end

    assign frame_done  = frameDone_q;
    assign frame_crc   = frameCrc_q;
    assign frame_lines = frameLines_q;
    assign line_len    = lineLen_q;
    assign line_err    = lineErr_q;
    assign frame_count = frameCount_q;
    assign done        = (state_q == VFM_DONE);

`ifdef VFM_XY_OUT_EN
    logic [X_W-1:0] pixX_q;
    logic [Y_W-1:0] pixY_q;
    logic           pixValid_q;

    // Position of each captured pixel, presented the clock after its sample.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pixX_q     <= '0;
            pixY_q     <= '0;
            pixValid_q <= 1'b0;
        end else begin
            pixValid_q <= enable & inCapture & active;
            if (enable && inCapture && active) begin
                pixX_q <= pixCnt_q;
                pixY_q <= lines_q;
            end
        end
    end

    assign pix_x     = pixX_q;
    assign pix_y     = pixY_q;
    assign pix_valid = pixValid_q;
`endif

endmodule

// File: tb/tb_video_frame_monitor.sv
// Self-checking bench for video_frame_monitor: table of frames driven with clock_en
// on every second clock, expected frame results queued and compared on frame_done.
module tb_video_frame_monitor;

    localparam int NUM_FRAMES = 3;
    localparam int X_W        = 10;
    localparam int Y_W        = 9;

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic           clock_en = 1'b0;
    logic           enable = 1'b0;
    logic [2:0]     video_r = '0, video_g = '0, video_b = '0;
    logic           hsync_n = 1'b1, vsync_n = 1'b1;
    logic           frame_done;
    logic [15:0]    frame_crc;
    logic [Y_W-1:0] frame_lines;
    logic [X_W-1:0] line_len;
    logic           line_err;
    logic [7:0]     frame_count;
    logic           done;

    video_frame_monitor #(.COLOR_W(3), .NUM_FRAMES(NUM_FRAMES), .MAX_X(1023), .MAX_Y(511)) dut (
        .clock       (clock),
        .reset       (reset),
        .clock_en    (clock_en),
        .enable      (enable),
        .video_r     (video_r),
        .video_g     (video_g),
        .video_b     (video_b),
        .hsync_n     (hsync_n),
        .vsync_n     (vsync_n),
        .frame_done  (frame_done),
        .frame_crc   (frame_crc),
        .frame_lines (frame_lines),
        .line_len    (line_len),
        .line_err    (line_err),
        .frame_count (frame_count),
        .done        (done)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [15:0] crc;
        int          lines;
        int          len;
        logic        err;
        int          count;
        logic        done;
    } expRec_t;

    typedef struct {
        int          nLines;
        logic [31:0] lens;
        int          pat;
        logic        simul;
        logic        expectOut;
        int          expLines;
        int          expLen;
        logic        expErr;
    } frameVec_t;

    expRec_t     expQ[$];
    expRec_t     monE;
    frameVec_t   vec[7];
    int          checks = 0;
    int          failures = 0;
    int          expCount = 0;
    logic [15:0] lastCrc = '0;

    // Reference CRC-16-CCITT over one 9-bit pixel, written as XOR-into-top then shift.
    function automatic logic [15:0] tbCrc(input logic [15:0] c, input logic [8:0] px);
        logic [15:0] r;
        r = c;
        for (int i = 8; i >= 0; i--) begin
            r = r ^ {px[i], 15'b0};
            if (r[15]) r = {r[14:0], 1'b0} ^ 16'h1021;
            else       r = {r[14:0], 1'b0};
        end
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One pixel-strobe sample: clock_en high for one clock, then a clock of garbage with clock_en low.
    task automatic applyStimulus(input logic h, input logic v, input logic [8:0] px);
        hsync_n  = h;
        vsync_n  = v;
        {video_r, video_g, video_b} = px;
        clock_en = 1'b1;
        @(negedge clock);
        clock_en = 1'b0;
        hsync_n  = 1'($urandom);
        vsync_n  = 1'($urandom);
        {video_r, video_g, video_b} = 9'($urandom);
        @(negedge clock);
    endtask

    task automatic driveFrame(input int i);
        logic [15:0] crc;
        logic [8:0]  px;
        int          len;
        crc = 16'hFFFF;
        for (int ln = 0; ln < vec[i].nLines; ln++) begin
            len = int'(vec[i].lens[8*ln +: 8]);
            for (int p = 0; p < len; p++) begin
                px  = (vec[i].pat != 0) ? 9'($urandom) : 9'd0;
                crc = tbCrc(crc, px);
                applyStimulus(1'b1, 1'b1, px);
            end
            if (!(vec[i].simul && ln == vec[i].nLines - 1)) applyStimulus(1'b0, 1'b1, 9'd0);
        end
        if (vec[i].expectOut) begin
            expCount++;
            expQ.push_back('{crc, vec[i].expLines, vec[i].expLen, vec[i].expErr,
                             expCount, logic'(expCount == NUM_FRAMES)});
            lastCrc = crc;
        end
        if (vec[i].simul) applyStimulus(1'b0, 1'b0, 9'd0);
        else              applyStimulus(1'b1, 1'b0, 9'd0);
        applyStimulus(1'b0, 1'b1, 9'd0);
    endtask

    // Scoreboard: every frame_done pops one expected record and compares the latched results.
    always @(negedge clock) begin
        if (!reset && frame_done) begin
            if (expQ.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_frame_done actual=1 required=0");
            end else begin
                monE = expQ.pop_front();
                checkOutput("frame_crc",   32'(frame_crc),   32'(monE.crc));
                checkOutput("frame_lines", 32'(frame_lines), 32'(monE.lines));
                checkOutput("line_len",    32'(line_len),    32'(monE.len));
                checkOutput("line_err",    32'(line_err),    32'(monE.err));
                checkOutput("frame_count", 32'(frame_count), 32'(monE.count));
                checkOutput("done_at_frame", 32'(done),      32'(monE.done));
            end
        end
    end

    initial begin
        vec[0] = '{4, 32'h08080808, 0, 1'b0, 1'b1, 4, 8, 1'b0};
        vec[1] = '{0, 32'h00000000, 0, 1'b0, 1'b1, 0, 0, 1'b0};
        vec[2] = '{3, 32'h00070808, 1, 1'b0, 1'b1, 3, 8, 1'b1};
        vec[3] = '{2, 32'h00000606, 1, 1'b0, 1'b0, 0, 0, 1'b0};
        vec[4] = '{1, 32'h00000003, 1, 1'b0, 1'b0, 0, 0, 1'b0};
        vec[5] = '{3, 32'h00080808, 1, 1'b0, 1'b1, 3, 8, 1'b0};
        vec[6] = '{3, 32'h00050404, 1, 1'b1, 1'b1, 3, 4, 1'b1};

        repeat (3) @(negedge clock);
        checkOutput("rst_frame_crc",   32'(frame_crc),   32'h0);
        checkOutput("rst_frame_lines", 32'(frame_lines), 32'h0);
        checkOutput("rst_line_len",    32'(line_len),    32'h0);
        checkOutput("rst_line_err",    32'(line_err),    32'h0);
        checkOutput("rst_frame_count", 32'(frame_count), 32'h0);
        checkOutput("rst_done",        32'(done),        32'h0);
        checkOutput("rst_frame_done",  32'(frame_done),  32'h0);

        reset = 1'b0;
        @(negedge clock);
        enable = 1'b1;
        @(negedge clock);
        applyStimulus(1'b1, 1'b1, 9'h1A5);
        applyStimulus(1'b0, 1'b1, 9'h000);
        applyStimulus(1'b1, 1'b1, 9'h0F0);
        applyStimulus(1'b1, 1'b1, 9'h000);
        checkOutput("sync_frame_crc",   32'(frame_crc),   32'h0);
        checkOutput("sync_frame_count", 32'(frame_count), 32'h0);
        checkOutput("sync_done",        32'(done),        32'h0);

        applyStimulus(1'b1, 1'b0, 9'd0);
        applyStimulus(1'b0, 1'b1, 9'd0);
        for (int i = 0; i < 5; i++) driveFrame(i);
        repeat (2) @(negedge clock);
        checkOutput("crc_frozen",        32'(frame_crc),   32'(lastCrc));
        checkOutput("done_held",         32'(done),        32'h1);
        checkOutput("count_held",        32'(frame_count), 32'(NUM_FRAMES));
        checkOutput("lines_held",        32'(frame_lines), 32'd3);

        enable = 1'b0;
        repeat (2) @(negedge clock);
        checkOutput("disarm_frame_count", 32'(frame_count), 32'h0);
        checkOutput("disarm_done",        32'(done),        32'h0);
        checkOutput("disarm_crc_kept",    32'(frame_crc),   32'(lastCrc));
        checkOutput("disarm_err_kept",    32'(line_err),    32'h1);

        expCount = 0;
        enable   = 1'b1;
        @(negedge clock);
        applyStimulus(1'b1, 1'b1, 9'd0);
        applyStimulus(1'b1, 1'b0, 9'd0);
        applyStimulus(1'b0, 1'b1, 9'd0);
        for (int i = 5; i < 7; i++) driveFrame(i);

        applyStimulus(1'b1, 1'b1, 9'h155);
        applyStimulus(1'b1, 1'b1, 9'h0AA);
        #2 reset = 1'b1;
        #1;
        checkOutput("areset_frame_crc",   32'(frame_crc),   32'h0);
        checkOutput("areset_frame_lines", 32'(frame_lines), 32'h0);
        checkOutput("areset_line_len",    32'(line_len),    32'h0);
        checkOutput("areset_line_err",    32'(line_err),    32'h0);
        checkOutput("areset_frame_count", 32'(frame_count), 32'h0);
        checkOutput("areset_done",        32'(done),        32'h0);
        checkOutput("pending_frame_done", 32'(expQ.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
